// File: rtl/lfsr_pkg.sv
// +-----------------------------------------------------------------+
// | lfsr_pkg : shared constants for the LFSR generator and readout   |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package lfsr_pkg;

  localparam logic [7:0] TAPS8 = 8'h1D;

  // Active-low {a,b,c,d,e,f,g,dp}; dp kept off in every entry
  localparam logic [7:0] SEG_HEX [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
// +-----------------------------------------------------------------+
// | hex7seg : one nibble to active-low seven-segment pattern         |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module hex7seg
  import lfsr_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_HEX[nib_i];

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// +-----------------------------------------------------------------+
// | lfsr_gen : Fibonacci LFSR with seed load, step mode, period      |
// |            measurement and hex seven-segment readout             |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter  int               WIDTH  = 8,
  parameter  logic [WIDTH-1:0] TAPS   = WIDTH'(TAPS8),
  localparam int               DIGITS = (WIDTH + 3) / 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      seed,
  input  logic                  load,
  input  logic                  en,
  input  logic                  free_run,
  input  logic                  step,
  output logic [WIDTH-1:0]      value,
  output logic [8*DIGITS-1:0]   seg,
  output logic                  wrap,
  output logic [WIDTH-1:0]      period
);

  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_CNT_MAX = '1;

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             step_q;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed_g;
  logic             w_adv;

  assign w_next   = {^(value_q & TAPS), value_q[WIDTH-1:1]};
  assign w_seed_g = (seed == '0) ? C_ONE : seed;
  assign w_adv    = en & (free_run | (step & ~step_q));

  always_comb begin
    value_d  = value_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    if (reset) begin
      value_d  = w_seed_g;
      seed_d   = w_seed_g;
      cnt_d    = '0;
      period_d = '0;
    end else if (load) begin
      value_d = w_seed_g;
      seed_d  = w_seed_g;
      cnt_d   = '0;
    end else if (w_adv) begin
      value_d = w_next;
      if (w_next == seed_q) begin
        wrap_d = 1'b1;
        cnt_d  = '0;
        // A saturated count no longer holds a true length
        if (cnt_q != C_CNT_MAX) period_d = cnt_q + C_ONE;
      end else if (cnt_q != C_CNT_MAX) begin
        cnt_d = cnt_q + C_ONE;
      end
    end
  end

  // step_q samples through reset so a held button cannot fire on release
  always_ff @(posedge clk) begin
    value_q  <= value_d;
    seed_q   <= seed_d;
    cnt_q    <= cnt_d;
    period_q <= period_d;
    wrap_q   <= wrap_d;
    step_q   <= step;
  end

  assign value  = value_q;
  assign wrap   = wrap_q;
  assign period = period_q;

  logic [4*DIGITS-1:0] w_value_pad;
  assign w_value_pad = (4*DIGITS)'(value_q);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    hex7seg u_hex7seg (
      .nib_i (w_value_pad[4*k +: 4]),
      .seg_o (seg[8*k +: 8])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// +-----------------------------------------------------------------+
// | tb_lfsr_gen : directed checks on an 8-bit and a 4-bit instance   |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8 = 1'b1, load8 = 1'b0, en8 = 1'b0, fr8 = 1'b0, step8 = 1'b0;
  logic [7:0]  seed8 = 8'h01;
  logic [7:0]  value8, period8;
  logic [15:0] seg8;
  logic        wrap8;

  logic        rst4 = 1'b1, load4 = 1'b0, en4 = 1'b0, fr4 = 1'b0, step4 = 1'b0;
  logic [3:0]  seed4 = 4'h1;
  logic [3:0]  value4, period4;
  logic [7:0]  seg4;
  logic        wrap4;

  lfsr_gen #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst8), .seed(seed8), .load(load8), .en(en8),
    .free_run(fr8), .step(step8), .value(value8), .seg(seg8),
    .wrap(wrap8), .period(period8)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011)) u_dut4 (
    .clk(clk), .reset(rst4), .seed(seed4), .load(load4), .en(en4),
    .free_run(fr4), .step(step4), .value(value4), .seg(seg4),
    .wrap(wrap4), .period(period4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        fr;
    logic        st;
    logic [7:0]  val;
    logic [15:0] seg;
  } vec_t;

  vec_t       vt [13];
  logic [3:0] seq4 [15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic zero_seen;

    vt[0]  = '{1'b1, 1'b1, 1'b0, 8'h80, 16'h0103};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 8'h40, 16'h9903};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 8'h40, 16'h9903};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 8'h20, 16'h2503};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 8'h10, 16'h9F03};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 8'h10, 16'h9F03};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 8'h88, 16'h0101};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 8'h88, 16'h0101};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h88, 16'h0101};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h88, 16'h0101};
    vt[10] = '{1'b1, 1'b0, 1'b1, 8'h88, 16'h0101};
    vt[11] = '{1'b1, 1'b1, 1'b0, 8'hC4, 16'h6399};
    vt[12] = '{1'b1, 1'b1, 1'b0, 8'hE2, 16'h6125};

    seq4 = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
             4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

    // reset state
    tick();
    check("rst_value8", value8, 8'h01);
    check("rst_seg8", seg8, 16'h039F);
    check("rst_wrap8", wrap8, 1'b0);
    check("rst_period8", period8, 8'h00);
    check("rst_value4", value4, 4'h1);
    check("rst_seg4", seg4, 8'h9F);
    check("rst_period4", period4, 4'h0);
    rst8 = 1'b0;
    rst4 = 1'b0;

    // vector table on the 8-bit instance
    for (int i = 0; i < 13; i++) begin
      en8 = vt[i].en; fr8 = vt[i].fr; step8 = vt[i].st;
      tick();
      check($sformatf("vec%0d_value", i), value8, vt[i].val);
      check($sformatf("vec%0d_seg", i), seg8, vt[i].seg);
      check($sformatf("vec%0d_wrap", i), wrap8, 1'b0);
    end

    // zero guard on reset and load (load also beats a same-cycle advance)
    rst8 = 1'b1; seed8 = 8'h00; en8 = 1'b1; fr8 = 1'b1; step8 = 1'b0;
    tick();
    check("zero_reset", value8, 8'h01);
    rst8 = 1'b0; load8 = 1'b1;
    tick();
    check("zero_load", value8, 8'h01);
    load8 = 1'b0;
    zero_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (value8 == 8'h00) zero_seen = 1'b1;
    end
    check("zero_never", zero_seen, 1'b0);

    // load versus advance
    load8 = 1'b1; seed8 = 8'h5A;
    tick();
    check("prio_load", value8, 8'h5A);
    load8 = 1'b0;
    tick();
    check("prio_next", value8, 8'h2D);
    en8 = 1'b0;

    // full period on the 4-bit instance
    en4 = 1'b1; fr4 = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check($sformatf("per_value%0d", i), value4, seq4[(i-1) % 15]);
      check($sformatf("per_wrap%0d", i), wrap4, (i == 15 || i == 30));
      if (i == 15 || i == 30) check($sformatf("per_period%0d", i), period4, 4'd15);
    end

    // mid-run reset
    rst4 = 1'b1; seed4 = 4'h1;
    tick();
    check("mrst_value", value4, 4'h1);
    check("mrst_period", period4, 4'h0);
    check("mrst_wrap", wrap4, 1'b0);
    rst4 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("mrst_seq%0d", i), value4, seq4[i-1]);
    end
    check("mrst_wrap15", wrap4, 1'b1);
    check("mrst_period15", period4, 4'd15);

    // load mid-count must restart the step counter
    tick(); tick(); tick();
    load4 = 1'b1; seed4 = 4'h1;
    tick();
    check("ldcnt_value", value4, 4'h1);
    load4 = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (wrap4) begin
        n = i;
        break;
      end
    end
    check("ldcnt_wrap_at", n, 15);
    check("ldcnt_period", period4, 4'd15);

    // single-step, with step already high through reset release
    rst4 = 1'b1; seed4 = 4'h1; fr4 = 1'b0; en4 = 1'b1; step4 = 1'b1;
    tick();
    rst4 = 1'b0;
    tick(); tick(); tick();
    check("step_held_rst", value4, 4'h1);
    step4 = 1'b0;
    tick(); tick();
    step4 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("step_first", value4, 4'h8);
    step4 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    step4 = 1'b1;
    tick();
    step4 = 1'b0;
    tick();
    check("step_second", value4, 4'h4);
    check("step_seg", seg4, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
